// File: rtl/if_id_if.sv
// if_id_if: fetch-side handshake and IF/ID decode bundle between the stage and its neighbours.
`ifndef REGISTER_BITS
`define REGISTER_BITS 4:0
`endif
interface if_id_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   hold;
  logic                   br_taken;
  logic [ADDR_WIDTH-1:0]  br_target;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [ADDR_WIDTH-1:0]  if_id_pc4;
  logic                   if_id_valid;
  logic [`REGISTER_BITS]  if_id_rs;
  logic [`REGISTER_BITS]  if_id_rt;
  logic                   if_id_branch;
  modport master (
    output hold, br_taken, br_target, imem_rdata, imem_ready,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, if_id_rs, if_id_rt, if_id_branch
  );
  modport slave (
    input  hold, br_taken, br_target, imem_rdata, imem_ready,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, if_id_rs, if_id_rt, if_id_branch
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: MIPS fetch stage and IF/ID register with hold, branch redirect and bubbles.
// Optional IF_STALL_CNT_EN adds saturating hold_cnt/bubble_cnt outputs.
module if_id_stage #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef IF_STALL_CNT_EN
  output logic [31:0] hold_cnt,
  output logic [31:0] bubble_cnt,
`endif
  if_id_if.slave     bus
);
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, pc4_q, pc4_d, pc_plus4;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d, fetch;
  always_comb begin
    pc_plus4 = pc_q + ADDR_WIDTH'(4);
    fetch    = !bus.hold && !bus.br_taken && bus.imem_ready;
    pc_d     = bus.hold ? pc_q : bus.br_taken ? bus.br_target : bus.imem_ready ? pc_plus4 : pc_q;
    instr_d  = bus.hold ? instr_q : fetch ? bus.imem_rdata : NOP_INSTR;
    pc4_d    = bus.hold ? pc4_q : fetch ? pc_plus4 : '0;
    valid_d  = bus.hold ? valid_q : fetch;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  // Decode is combinational from the registers so the hazard unit sees it in the same cycle.
  assign bus.imem_addr    = pc_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.if_id_rs     = instr_q[25:21];
  assign bus.if_id_rt     = instr_q[20:16];
  assign bus.if_id_branch = valid_q && (instr_q[31:26] == 6'h04 || instr_q[31:26] == 6'h05);
`ifdef IF_STALL_CNT_EN
  logic [31:0] hold_cnt_q, hold_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    hold_cnt_d   = (bus.hold && ~&hold_cnt_q) ? hold_cnt_q + 32'd1 : hold_cnt_q;
    bubble_cnt_d = (!bus.hold && (bus.br_taken || !bus.imem_ready) && ~&bubble_cnt_q)
                   ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  assign hold_cnt   = hold_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule
